// File: rtl/ir_uart_rx.sv
// ir_uart_rx: 8N1 UART receiver for the IR camera configuration link.
// Runs in the iClk domain directly behind the iIR_UART_RxD pin. It delivers
// received bytes through a valid/ready handshake and flags framing errors and
// overruns with one-cycle pulses.
//
// Ports:
//   iClk      system clock, rising edge
//   iRst      synchronous reset, active-high
//   iRxD      asynchronous serial line, idle high
//   oData     received byte, valid while oValid=1
//   oValid    byte available
//   iReady    consumer accepts oData when oValid && iReady
//   oFrameErr one-cycle pulse: stop bit sampled low
//   oOverrun  one-cycle pulse: byte completed while the holding register was
//             full and not being drained
//   oBusy     high while receiving a frame (START, DATA, STOP)
module ir_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 417,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iRxD,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oFrameErr,
  output logic       oOverrun,
  output logic       oBusy
);

  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
  // Cycles spent in WAIT_HIGH before trusting the synchroniser output.
  localparam logic [CNT_W-1:0] FLUSH_CY = CNT_W'(2);

  typedef enum logic [2:0] {
    ST_WAIT_HIGH,
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           state_q;
  logic [1:0]       sync_q;
  logic [2:0]       hist_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             busy_q;

  logic line_c;
  logic maj_c;

  // Synchronised line and 2-of-3 vote over the current and two previous cycles.
  always_comb begin
    line_c = sync_q[1];
    maj_c  = (hist_q[1] & hist_q[0]) | (hist_q[1] & line_c) | (hist_q[0] & line_c);
  end

  // Synchroniser, sample history, receive FSM and output holding register.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q     <= ST_WAIT_HIGH;
      sync_q      <= 2'b11;
      hist_q      <= 3'b111;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], iRxD};
      hist_q      <= {hist_q[1:0], line_c};
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumer drain; a byte completing this cycle overrides it below.
      if (valid_q && iReady) begin
        valid_q <= 1'b0;
      end

      case (state_q)
        ST_WAIT_HIGH: begin
          // The synchroniser still shows its reset value for two cycles, so
          // hold off until it carries the real line level; otherwise a reset
          // with the line low would look like idle followed by a start edge.
          if (cnt_q < FLUSH_CY) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else if (line_c) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end
        end

        ST_IDLE: begin
          if (!line_c) begin
            state_q <= ST_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            if (maj_c) begin
              // Low pulse shorter than half a bit: treat as a glitch.
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q     <= '0;
            shift_q   <= {maj_c, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= ST_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
            if (maj_c) begin
              state_q <= ST_IDLE;
              if (!valid_q || iReady) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              // Bad stop bit: drop the byte and wait for the line to recover.
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_q <= ST_WAIT_HIGH;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oData     = data_q;
  assign oValid    = valid_q;
  assign oFrameErr = frame_err_q;
  assign oOverrun  = overrun_q;
  assign oBusy     = busy_q;

endmodule

// File: tb/tb_ir_uart_rx.sv
// tb_ir_uart_rx: directed testbench for ir_uart_rx with 16 clocks per bit.
module tb_ir_uart_rx;

  localparam int unsigned CPB = 16;
  // Cycles from driving the start bit to oValid being visible:
  // 2 sync + 1 idle decision + half bit + 8 data bits + stop bit.
  localparam int RISE_OFS = 3 + CPB / 2 + 9 * CPB;

  logic       iClk = 1'b0;
  logic       iRst;
  logic       iRxD;
  logic [7:0] oData;
  logic       oValid;
  logic       iReady;
  logic       oFrameErr;
  logic       oOverrun;
  logic       oBusy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Monitor counters, sampled on the falling edge.
  int         v_cycles  = 0;
  int         v_rises   = 0;
  int         rise_cyc  = 0;
  logic [7:0] rise_data = 8'h00;
  int         fe_cycles = 0;
  int         ov_cycles = 0;
  int         both_cnt  = 0;
  int         busy_cyc  = 0;
  int         busy_fall = 0;
  logic       v_prev    = 1'b0;
  logic       b_prev    = 1'b0;

  int start_cyc;
  int s_rises, s_vcyc, s_fe, s_ov, s_busy;

  ir_uart_rx #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .iClk      (iClk),
    .iRst      (iRst),
    .iRxD      (iRxD),
    .oData     (oData),
    .oValid    (oValid),
    .iReady    (iReady),
    .oFrameErr (oFrameErr),
    .oOverrun  (oOverrun),
    .oBusy     (oBusy)
  );

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  always @(negedge iClk) begin
    if (oValid === 1'b1) v_cycles++;
    if (oValid === 1'b1 && v_prev !== 1'b1) begin
      v_rises++;
      rise_cyc  = cyc;
      rise_data = oData;
    end
    v_prev = oValid;
    if (oFrameErr === 1'b1) fe_cycles++;
    if (oOverrun === 1'b1) ov_cycles++;
    if (oFrameErr === 1'b1 && oOverrun === 1'b1) both_cnt++;
    if (oBusy === 1'b1) busy_cyc++;
    if (oBusy !== 1'b1 && b_prev === 1'b1) busy_fall = cyc;
    b_prev = oBusy;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge iClk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    iRxD = b;
    tick(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop_bit);
  endtask

  task automatic snap();
    s_rises = v_rises;
    s_vcyc  = v_cycles;
    s_fe    = fe_cycles;
    s_ov    = ov_cycles;
    s_busy  = busy_cyc;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    iRst   = 1'b1;
    iRxD   = 1'b1;
    iReady = 1'b1;
    tick(3);
    chk("reset_data",  32'(oData),     32'h00);
    chk("reset_valid", 32'(oValid),    32'h0);
    chk("reset_fe",    32'(oFrameErr), 32'h0);
    chk("reset_ov",    32'(oOverrun),  32'h0);
    chk("reset_busy",  32'(oBusy),     32'h0);
    iRst = 1'b0;
    tick(10);

    // 0xA5 with iReady held high.
    snap();
    send_frame(8'hA5, 1'b1);
    tick(10);
    chk("a5_rises",   32'(v_rises - s_rises),     32'd1);
    chk("a5_data",    32'(rise_data),             32'hA5);
    chk("a5_latency", 32'(rise_cyc - start_cyc),  32'(RISE_OFS));
    chk("a5_vcycles", 32'(v_cycles - s_vcyc),     32'd1);
    chk("a5_fe",      32'(fe_cycles - s_fe),      32'd0);
    chk("a5_ov",      32'(ov_cycles - s_ov),      32'd0);
    chk("a5_valid_end", 32'(oValid),              32'h0);

    // 0x3C then 0xC3 back-to-back with no consumer.
    iReady = 1'b0;
    snap();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    tick(5);
    chk("ovr_data",  32'(oData),                32'h3C);
    chk("ovr_valid", 32'(oValid),               32'h1);
    chk("ovr_pulse", 32'(ov_cycles - s_ov),     32'd1);
    chk("ovr_rises", 32'(v_rises - s_rises),    32'd1);
    chk("ovr_fe",    32'(fe_cycles - s_fe),     32'd0);
    iReady = 1'b1;
    tick(1);
    chk("ovr_drain", 32'(oValid),               32'h0);
    chk("ovr_hold",  32'(oData),                32'h3C);

    // 0x55 with a low stop bit, then 0x12.
    tick(10);
    snap();
    send_frame(8'h55, 1'b0);
    iRxD = 1'b1;
    tick(30);
    chk("fe_pulse", 32'(fe_cycles - s_fe),      32'd1);
    chk("fe_rises", 32'(v_rises - s_rises),     32'd0);
    chk("fe_valid", 32'(oValid),                32'h0);
    chk("fe_data",  32'(oData),                 32'h3C);
    snap();
    send_frame(8'h12, 1'b1);
    tick(10);
    chk("post_fe_rises", 32'(v_rises - s_rises), 32'd1);
    chk("post_fe_data",  32'(rise_data),         32'h12);
    chk("post_fe_fe",    32'(fe_cycles - s_fe),  32'd0);

    // Three-cycle low glitch on an idle line.
    tick(10);
    snap();
    start_cyc = cyc;
    iRxD = 1'b0;
    tick(3);
    iRxD = 1'b1;
    tick(30);
    chk("gl_rises",     32'(v_rises - s_rises),        32'd0);
    chk("gl_fe",        32'(fe_cycles - s_fe),         32'd0);
    chk("gl_busy_cyc",  32'(busy_cyc - s_busy),        32'(CPB / 2));
    chk("gl_busy_fall", 32'(busy_fall - start_cyc),    32'(3 + CPB / 2));
    chk("gl_busy_end",  32'(oBusy),                    32'h0);

    // Reset in the middle of 0xFF with the line pulled low.
    tick(10);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    iRxD = 1'b0;
    tick(8);
    chk("mid_busy", 32'(oBusy), 32'h1);
    iRst = 1'b1;
    tick(1);
    iRst = 1'b0;
    chk("rst_data",  32'(oData),     32'h00);
    chk("rst_valid", 32'(oValid),    32'h0);
    chk("rst_busy",  32'(oBusy),     32'h0);
    chk("rst_fe",    32'(oFrameErr), 32'h0);
    chk("rst_ov",    32'(oOverrun),  32'h0);
    snap();
    tick(60);
    iRxD = 1'b1;
    tick(20);
    chk("abort_busy",  32'(busy_cyc - s_busy),  32'd0);
    chk("abort_rises", 32'(v_rises - s_rises),  32'd0);
    chk("abort_fe",    32'(fe_cycles - s_fe),   32'd0);
    snap();
    send_frame(8'h81, 1'b1);
    tick(10);
    chk("r81_rises", 32'(v_rises - s_rises), 32'd1);
    chk("r81_data",  32'(rise_data),         32'h81);

    // 0xFF with a one-cycle low glitch at the centre of data bit 3.
    tick(10);
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    iRxD = 1'b1;
    tick(CPB / 2);
    iRxD = 1'b0;
    tick(1);
    iRxD = 1'b1;
    tick(CPB / 2 - 1);
    for (int i = 4; i < 8; i++) send_bit(1'b1);
    send_bit(1'b1);
    tick(10);
    chk("vote_rises", 32'(v_rises - s_rises), 32'd1);
    chk("vote_data",  32'(rise_data),         32'hFF);
    chk("vote_fe",    32'(fe_cycles - s_fe),  32'd0);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_uart_rx.md
Name: ir_uart_rx

Overview:
- 8N1 UART receiver for the IR camera configuration link. Sits directly downstream of the iIR_UART_RxD pin, in the iClk (global PLL clock) domain.
- Delivers received bytes to the IR command/response logic through a valid/ready handshake.
- Flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 417, iClk cycles per UART bit (48 MHz / 115200). Legal range 8..65535.
- CNT_W, 16, width of the bit-timing counter. Must hold CLKS_PER_BIT-1.

Ports:
- iClk  input  1  system clock; all logic on the rising edge
- iRst  input  1  synchronous reset, active-high
- iRxD  input  1  asynchronous serial line, idle high
- oData  output  8  received byte, valid while oValid=1
- oValid  output  1  byte available
- iReady  input  1  consumer accepts oData when oValid&&iReady
- oFrameErr  output  1  one-cycle pulse: stop bit sampled low
- oOverrun  output  1  one-cycle pulse: byte completed while holding register full and not being drained
- oBusy  output  1  high in START, DATA, STOP states

Behaviour:
- Synchroniser: 2-flop sync on iRxD, reset value 1. "line" = second flop output.
- Majority sample: majority of line over 3 consecutive cycles ending at the sample cycle. Kept in a 3-bit history register, reset 3'b111.
- Bit counter cnt (CNT_W bits) is cleared on every state transition.
- FSM states: WAIT_HIGH, IDLE, START, DATA, STOP. Reset state is WAIT_HIGH, so a reset mid-frame cannot cause a false start.
- WAIT_HIGH: go to IDLE on the first cycle line=1.
- IDLE: line=0 goes to START.
- START: when cnt==CLKS_PER_BIT/2-1 (integer division), evaluate majority.
  - Majority 1: glitch; return to IDLE, no flags.
  - Majority 0: go to DATA, bit index=0.
- DATA: when cnt==CLKS_PER_BIT-1, shift majority into the shift register MSB (LSB first on the wire) and increment the bit index. After the 8th bit, go to STOP.
- STOP: when cnt==CLKS_PER_BIT-1, evaluate majority.
  - Majority 1: byte complete; go to IDLE.
  - Majority 0: pulse oFrameErr for 1 cycle, discard the byte, go to WAIT_HIGH.
- Delivery, on byte complete (in the cycle after the stop sample):
  - oValid=0, or oValid=1 with iReady=1 in that cycle: oData<=shift register, oValid<=1. A back-to-back accept plus load keeps oValid high.
  - oValid=1 with iReady=0: new byte dropped, oData unchanged, oOverrun pulses 1 cycle.
- Handshake: oValid=1 && iReady=1 with no new byte completing: oValid<=0 next cycle. oData holds its value until the next load.
- Latency: oValid rises 1 cycle after the stop-bit sample cycle.
- Reset values: oData=8'h00, oValid=0, oFrameErr=0, oOverrun=0, oBusy=0, shift register=0, cnt=0, bit index=0.
- oFrameErr and oOverrun never assert in the same cycle: a framing error never loads a byte.
- iReady while oValid=0 is ignored.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 8N1 with iReady=1 held:
  - oData=8'hA5 and oValid high for exactly 1 cycle.
  - oValid rises 1 cycle after the stop-bit sample.
  - oFrameErr=0 and oOverrun=0.
- Send 0x3C then 0xC3 back-to-back with iReady=0 until after the second stop bit:
  - oData stays 8'h3C with oValid=1.
  - oOverrun pulses once.
  - After iReady=1 for one cycle, oValid=0.
- Send 0x55 with the stop bit driven low, then line high:
  - oFrameErr pulses 1 cycle and oValid stays 0.
  - A following 0x12 is received correctly.
- Drive iRxD low for 3 cycles, then high (glitch shorter than half a bit):
  - No oValid, no oFrameErr.
  - oBusy high, then low at the start-sample point.
- Assert iRst for 1 cycle mid-DATA of 0xFF with the line still low:
  - All outputs return to their reset values.
  - Receiver waits in WAIT_HIGH; no byte and no error is produced for the aborted frame.
  - The next frame 0x81 is received correctly.
- Single-cycle low glitch at the centre of data bit 3 of 0xFF:
  - Majority vote rejects it; oData=8'hFF.
